// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic valid/ready pipeline stage with 2-entry skid buffer and synchronous flush.
// Optional performance counters are enabled by defining PIPE_SKID_PERF_EN.
`default_nettype none

module pipe_skid_reg #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       full_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  // All handshake outputs decode the state flops only, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (state != TWO);
  assign out_valid_o = (state != EMPTY);
  assign occupancy_o = state;
  assign out_data_o  = main_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_nxt = state;
    main_d    = main_q;
    skid_d    = skid_q;
    if (flush_i) begin
      state_nxt = EMPTY;
      main_d    = RESET_VAL;
      skid_d    = RESET_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_d    = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_d    = in_data_i;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_d    = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  // Counters survive flush and wrap naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      full_cnt_o  <= '0;
    end else begin
      if (out_valid_o && !out_ready_i) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (state == TWO) begin
        full_cnt_o <= full_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table, hand sequences and randomized run against a queue model.
`default_nettype none

module tb_pipe_skid_reg;

  localparam int          DATA_W = 32;
  localparam logic [31:0] RV     = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       full_cnt;
`endif

  pipe_skid_reg #(.DATA_W(DATA_W), .RESET_VAL(RV)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .occupancy_o (occ)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .full_cnt_o  (full_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a FIFO of at most two items plus the last value seen at the head.
  logic [31:0] mq[$];
  logic [31:0] m_last;
  int unsigned m_stall, m_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last  = RV;
    m_stall = 0;
    m_full  = 0;
  endtask

  task automatic model_step();
    bit ifire, ofire;
    ifire = in_valid && (mq.size() < 2);
    ofire = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready) m_stall++;
    if (mq.size() == 2) m_full++;
    if (flush) begin
      mq.delete();
      m_last = RV;
    end else begin
      if (ofire) m_last = mq.pop_front();
      if (ifire) begin
        mq.push_back(in_data);
        if (mq.size() == 1) m_last = in_data;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, " out_data"},  out_data,       (mq.size() > 0) ? mq[0] : m_last);
    chk({tag, " occupancy"}, 32'(occ),       32'(mq.size()));
`ifdef PIPE_SKID_PERF_EN
    chk({tag, " stall_cnt"}, stall_cnt, m_stall);
    chk({tag, " full_cnt"},  full_cnt,  m_full);
`endif
  endtask

  // One clock: model and DUT advance on the same edge, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit f, input bit iv, input logic [31:0] d, input bit ordy);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"},  out_data,       RV);
    chk({tag, " occupancy"}, 32'(occ),       32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    bit          flush;
    bit          in_valid;
    logic [31:0] data;
    bit          out_ready;
    bit          e_ir;
    bit          e_ov;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vec[13];

  initial begin
    vec[0]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1};
    vec[1]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2};
    vec[2]  = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2};
    vec[3]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
    vec[4]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1};
    vec[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h33, 2'd0};
    vec[6]  = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55, 2'd1};
    vec[7]  = '{1'b0, 1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 32'h55, 2'd2};
    vec[8]  = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, RV,     2'd0};
    vec[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, RV,     2'd0};
    vec[10] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, RV,     2'd0};
    vec[11] = '{1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 32'h77, 2'd1};
    vec[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, RV,     2'd0};

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    async_reset("reset");

    // Backpressure, release and flush corner cases.
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].flush, vec[i].in_valid, vec[i].data, vec[i].out_ready);
      cycle();
      chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vec[i].e_ir));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
      chk($sformatf("vec%0d out_data", i),  out_data,       vec[i].e_data);
      chk($sformatf("vec%0d occupancy", i), 32'(occ),       32'(vec[i].e_occ));
    end

    // Streaming at full rate.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 32'(k), 1'b1);
      cycle();
      chk($sformatf("stream%0d out_data", k), out_data, 32'(k));
      chk($sformatf("stream%0d in_ready", k), 32'(in_ready), 32'd1);
      chk($sformatf("stream%0d occupancy", k), 32'(occ), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    cycle();
    chk("stream drain out_valid", 32'(out_valid), 32'd0);

    // Reset while two entries are held, then first transfer after release.
    drive(1'b0, 1'b1, 32'hA1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 32'hA2, 1'b0);
    cycle();
    chk("burst occupancy", 32'(occ), 32'd2);
    async_reset("midreset");
    drive(1'b0, 1'b1, 32'h99, 1'b1);
    cycle();
    chk("post-reset out_data", out_data, 32'h99);
    chk("post-reset out_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    cycle();

`ifdef PIPE_SKID_PERF_EN
    // Counters: fill to two entries, stall five cycles, then flush.
    async_reset("perfreset");
    drive(1'b0, 1'b1, 32'hB1, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 32'hB2, 1'b0);
    cycle();
    begin
      logic [31:0] s0, f0;
      s0 = stall_cnt;
      f0 = full_cnt;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (5) cycle();
      chk("perf stall delta", stall_cnt - s0, 32'd5);
      chk("perf full delta",  full_cnt - f0,  32'd5);
      s0 = stall_cnt;
      f0 = full_cnt;
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      cycle();
      chk("perf stall after flush", stall_cnt, s0);
      chk("perf full after flush",  full_cnt,  f0 + 32'd1);
    end
    check_model("perf");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 24) == 0, 1'($urandom), $urandom, $urandom_range(0, 3) != 0);
      cycle();
      check_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
